// File: rtl/pistorm_pkg.sv
// Shared constants and state encoding for the 68000 bus-slave responder.
// Address widths, default window/timeout values and the address-decode helper.
package pistorm_pkg;

    localparam int ADDR_W      = 23;
    localparam int BYTE_ADDR_W = 24;
    localparam int DATA_W      = 16;
    localparam int CNT_W       = 8;

    localparam logic [CNT_W-1:0]       TIMEOUT_DEFAULT   = 8'd255;
    localparam logic [BYTE_ADDR_W-1:0] BASE_ADDR_DEFAULT = 24'h200000;
    localparam logic [BYTE_ADDR_W-1:0] ADDR_MASK_DEFAULT = 24'hE00000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_BACKEND = 3'd2,
        ST_ACK     = 3'd3,
        ST_FAULT   = 3'd4,
        ST_RELEASE = 3'd5
    } bus_state_t;

    // The bus carries word addresses; A0 is implied zero for the window compare.
    function automatic logic addr_hit(
        input logic [ADDR_W-1:0]      word_addr,
        input logic [BYTE_ADDR_W-1:0] base,
        input logic [BYTE_ADDR_W-1:0] mask
    );
        return (({word_addr, 1'b0} & mask) == (base & mask));
    endfunction

endpackage

// File: rtl/m68k_sync.sv
// Parameterized-width two-flop synchronizer with a selectable reset value,
// used to bring the asynchronous 68000 strobes into the PI_CLK domain.
module m68k_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 bus slave: decodes an address window, forwards hits to a backend
// through a request/ack handshake and answers the CPU with DTACK or BERR.
module m68k_bus_responder
    import pistorm_pkg::*;
#(
    parameter logic [BYTE_ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter logic [BYTE_ADDR_W-1:0] ADDR_MASK = ADDR_MASK_DEFAULT,
    parameter logic [CNT_W-1:0]       TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic              PI_CLK,
    input  logic              PI_RST,
    input  logic              M68K_AS_n,
    input  logic              M68K_UDS_n,
    input  logic              M68K_LDS_n,
    input  logic              M68K_RW,
    input  logic [ADDR_W-1:0] M68K_A,
    input  logic [DATA_W-1:0] M68K_D_IN,
    output logic [DATA_W-1:0] M68K_D_OUT,
    output logic              M68K_D_OE,
    output logic              M68K_DTACK_n,
    output logic              M68K_BERR_n,
    output logic              BK_REQ,
    output logic              BK_WE,
    output logic [ADDR_W-1:0] BK_ADDR,
    output logic [1:0]        BK_BE,
    output logic [DATA_W-1:0] BK_WDATA,
    input  logic              BK_ACK,
    input  logic [DATA_W-1:0] BK_RDATA
);

    logic [3:0] sync_q;
    logic       as_n_s;
    logic       uds_n_s;
    logic       lds_n_s;
    logic       rw_s;

    m68k_sync #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_sync (
        .clk (PI_CLK),
        .rst (PI_RST),
        .d   ({M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW}),
        .q   (sync_q)
    );

    assign {as_n_s, uds_n_s, lds_n_s, rw_s} = sync_q;

    logic as_low;
    logic ds_low;
    assign as_low = !as_n_s;
    assign ds_low = !uds_n_s || !lds_n_s;

    // settle_q marks when the synchronizer holds real samples after reset;
    // armed_q then requires one AS-high sighting so a cycle already in
    // flight across reset release is never picked up half-way.
    logic [1:0] settle_q;
    logic       armed_q;

    bus_state_t        state_q;
    bus_state_t        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              req_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [1:0]        be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] dout_d;
    logic              oe_d;
    logic              dtack_d;
    logic              berr_d;
    logic              ack_valid;

    assign cnt_inc = cnt_q + 8'd1;

    // Backend handshake: BK_REQ is raised once per transfer and held with
    // BK_ADDR/BK_BE/BK_WE/BK_WDATA stable until a single-cycle BK_ACK is
    // sampled while BK_REQ is high; an ack with BK_REQ low means nothing.
    assign ack_valid = BK_ACK && BK_REQ;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = BK_REQ;
        we_d    = BK_WE;
        addr_d  = BK_ADDR;
        be_d    = BK_BE;
        wdata_d = BK_WDATA;
        dout_d  = M68K_D_OUT;
        oe_d    = M68K_D_OE;
        dtack_d = M68K_DTACK_n;
        berr_d  = M68K_BERR_n;

        case (state_q)
            ST_IDLE: begin
                if (as_low && armed_q) begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                if (!as_low) begin
                    state_d = ST_IDLE;
                end else if (ds_low) begin
                    addr_d  = M68K_A;
                    be_d    = ~{uds_n_s, lds_n_s};
                    we_d    = ~rw_s;
                    wdata_d = M68K_D_IN;
                    if (addr_hit(M68K_A, BASE_ADDR, ADDR_MASK)) begin
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_BACKEND;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
            end

            ST_BACKEND: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (ack_valid) begin
                    req_d = 1'b0;
                    if (!BK_WE) begin
                        dout_d = BK_RDATA;
                    end
                    if (as_low) begin
                        dtack_d = 1'b0;
                        oe_d    = ~BK_WE;
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT) begin
                        req_d   = 1'b0;
                        berr_d  = 1'b0;
                        state_d = ST_FAULT;
                    end
                end
            end

            ST_ACK: begin
                if (!as_low) begin
                    dtack_d = 1'b1;
                    oe_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_FAULT: begin
                if (!as_low) begin
                    berr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_RELEASE: begin
                if (!as_low) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PI_CLK) begin
        if (PI_RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            settle_q     <= 2'b00;
            armed_q      <= 1'b0;
            BK_REQ       <= 1'b0;
            BK_WE        <= 1'b0;
            BK_ADDR      <= '0;
            BK_BE        <= 2'b00;
            BK_WDATA     <= '0;
            M68K_D_OUT   <= '0;
            M68K_D_OE    <= 1'b0;
            M68K_DTACK_n <= 1'b1;
            M68K_BERR_n  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            settle_q     <= {settle_q[0], 1'b1};
            armed_q      <= armed_q | (settle_q[1] & as_n_s);
            BK_REQ       <= req_d;
            BK_WE        <= we_d;
            BK_ADDR      <= addr_d;
            BK_BE        <= be_d;
            BK_WDATA     <= wdata_d;
            M68K_D_OUT   <= dout_d;
            M68K_D_OE    <= oe_d;
            M68K_DTACK_n <= dtack_d;
            M68K_BERR_n  <= berr_d;
        end
    end

endmodule
